// File: rtl/cache_mem_subsystem.sv
// ----------------------------------------------------------------------------
// cache_mem_subsystem
//
// Direct-mapped, write-back, write-allocate cache with one data word per line,
// sitting between a CPU request port and a simple memory port. At most one
// CPU request is in flight at a time.
//
// Ports
//   CLK, RST_N            clock, synchronous active-low reset
//   req_*                 CPU request (valid/ready), write flag, word address, store data
//   resp_valid/resp_rdata one-cycle completion pulse; load data (0 for stores)
//   mem_req_*             memory request (valid/ready): writeback or fill read
//   mem_resp_*            fill data return (only looked at while waiting for a fill)
//   hit_cnt/miss_cnt      saturating 16-bit statistics
//   stat_load_i           loads both statistics counters from stat_*_val_i
//   dbg_state_o           current FSM state, for observation only
//
// Handshake rule (both request ports): a transfer happens on a rising edge
// where valid and ready are both high. A source holding valid keeps every
// payload signal stable until that edge; ready may rise or fall freely.
// ----------------------------------------------------------------------------
module cache_mem_subsystem #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_LINES = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_write,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  input  logic              stat_load_i,
  input  logic [15:0]       stat_hit_val_i,
  input  logic [15:0]       stat_miss_val_i,
  output logic [2:0]        dbg_state_o
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WB        = 3'd1,
    S_FILL_REQ  = 3'd2,
    S_FILL_WAIT = 3'd3,
    S_RESP      = 3'd4
  } state_e;

  state_e              state_q;
  logic                req_ready_q;
  logic                req_write_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [DATA_W-1:0]   req_wdata_q;
  logic                resp_valid_q;
  logic [DATA_W-1:0]   resp_rdata_q;
  logic                mem_req_valid_q;
  logic                mem_req_write_q;
  logic [ADDR_W-1:0]   mem_req_addr_q;
  logic [DATA_W-1:0]   mem_req_wdata_q;
  logic [15:0]         hit_cnt_q,  hit_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;

  // Line state. Only valid/dirty are reset; tag/data are qualified by valid.
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [DATA_W-1:0]    data_q [NUM_LINES];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Lookup uses the live request inputs: the hit/miss decision is made on
  // the accepting edge itself, which gives the one-cycle load-hit latency.
  logic [IDX_W-1:0] in_idx;
  logic [TAG_W-1:0] in_tag;
  logic             in_hit;
  logic             in_victim_dirty;
  logic             accept;
  logic [IDX_W-1:0] cur_idx;

  assign in_idx          = req_addr[IDX_W-1:0];
  assign in_tag          = req_addr[ADDR_W-1:IDX_W];
  assign in_hit          = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign in_victim_dirty = valid_q[in_idx] && dirty_q[in_idx];
  assign accept          = req_valid && req_ready_q;
  assign cur_idx         = req_addr_q[IDX_W-1:0];

  assign hit_cnt_d  = sat_inc(hit_cnt_q);
  assign miss_cnt_d = sat_inc(miss_cnt_q);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q         <= S_IDLE;
      req_ready_q     <= 1'b0;
      req_write_q     <= 1'b0;
      req_addr_q      <= '0;
      req_wdata_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_write_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
      valid_q         <= '0;
      dirty_q         <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // First cycle out of reset lands here with ready low; raise it.
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            req_write_q <= req_write;
            req_addr_q  <= req_addr;
            req_wdata_q <= req_wdata;
            if (in_hit) begin
              hit_cnt_q    <= hit_cnt_d;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= req_write ? '0 : data_q[in_idx];
              if (req_write) begin
                data_q[in_idx]  <= req_wdata;
                dirty_q[in_idx] <= 1'b1;
              end
              state_q <= S_RESP;
            end else begin
              miss_cnt_q      <= miss_cnt_d;
              mem_req_valid_q <= 1'b1;
              if (in_victim_dirty) begin
                mem_req_write_q <= 1'b1;
                mem_req_addr_q  <= {tag_q[in_idx], in_idx};
                mem_req_wdata_q <= data_q[in_idx];
                state_q         <= S_WB;
              end else begin
                mem_req_write_q <= 1'b0;
                mem_req_addr_q  <= req_addr;
                mem_req_wdata_q <= '0;
                state_q         <= S_FILL_REQ;
              end
            end
          end
        end

        S_WB: begin
          // Writeback accepted: line is clean, go straight to the fill read.
          if (mem_req_ready) begin
            dirty_q[cur_idx] <= 1'b0;
            mem_req_write_q  <= 1'b0;
            mem_req_addr_q   <= req_addr_q;
            mem_req_wdata_q  <= '0;
            state_q          <= S_FILL_REQ;
          end
        end

        S_FILL_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            mem_req_addr_q  <= '0;
            state_q         <= S_FILL_WAIT;
          end
        end

        S_FILL_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[cur_idx] <= 1'b1;
            tag_q[cur_idx]   <= req_addr_q[ADDR_W-1:IDX_W];
            // Store miss allocates with the store data; fill data is dropped.
            data_q[cur_idx]  <= req_write_q ? req_wdata_q : mem_resp_rdata;
            dirty_q[cur_idx] <= req_write_q;
            resp_valid_q     <= 1'b1;
            resp_rdata_q     <= req_write_q ? '0 : mem_resp_rdata;
            state_q          <= S_RESP;
          end
        end

        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: begin
          req_ready_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase

      // Counter load overrides any increment on the same edge.
      if (stat_load_i) begin
        hit_cnt_q  <= stat_hit_val_i;
        miss_cnt_q <= stat_miss_val_i;
      end
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_write = mem_req_write_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign hit_cnt       = hit_cnt_q;
  assign miss_cnt      = miss_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cache_mem_subsystem.sv
// ----------------------------------------------------------------------------
// tb_cache_mem_subsystem
//
// Reference model: a flat architectural memory (shadow) plus a per-index
// record of which word address each line holds and whether it is dirty.
// Expected load data, writebacks and fills all follow from those. A memory
// responder process plays the memory and checks every memory request against
// the expected memory-transaction queue; a response monitor pops exp_q.
// All inputs change and all outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_cache_mem_subsystem;

  localparam int NUM_LINES = 16;

  // ---------------- clock / reset ----------------
  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic [15:0] hit_cnt, miss_cnt;
  logic        stat_load_i;
  logic [15:0] stat_hit_val_i, stat_miss_val_i;
  logic [2:0]  dbg_state_o;

  cache_mem_subsystem #(.ADDR_W(32), .DATA_W(32), .NUM_LINES(NUM_LINES)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .stat_load_i(stat_load_i), .stat_hit_val_i(stat_hit_val_i),
    .stat_miss_val_i(stat_miss_val_i), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
  } mem_txn_t;
  mem_txn_t exp_mem_q[$];
  int resp_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (state=%0d t=%0t)", name, dbg_state_o, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] shadow   [logic [31:0]];  // architectural view
  logic [31:0] mem_model[logic [31:0]];  // what main memory should hold
  logic [31:0] backing  [logic [31:0]];  // memory device contents
  logic        m_valid[NUM_LINES];
  logic        m_dirty[NUM_LINES];
  logic [31:0] m_addr [NUM_LINES];
  logic [15:0] m_hits, m_misses;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] arch_read(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : init_val(a);
  endfunction

  function automatic logic [15:0] sat_add1(input logic [15:0] v);
    int n;
    n = int'(v) + 1;
    return (n > 65535) ? 16'hFFFF : n[15:0];
  endfunction

  task automatic preset_mem(input logic [31:0] a, input logic [31:0] v);
    shadow[a] = v; mem_model[a] = v; backing[a] = v;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_addr[i] = '0;
    end
    m_hits = '0; m_misses = '0;
    shadow = mem_model;  // un-written-back stores are lost
  endtask

  task automatic model_issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input bit expect_resp, output bit hit);
    int idx;
    mem_txn_t t;
    idx = int'(a % NUM_LINES);
    hit = m_valid[idx] && (m_addr[idx] == a);
    if (hit) m_hits = sat_add1(m_hits);
    else begin
      m_misses = sat_add1(m_misses);
      if (m_valid[idx] && m_dirty[idx]) begin
        t.w = 1'b1; t.a = m_addr[idx]; t.d = arch_read(m_addr[idx]);
        exp_mem_q.push_back(t);
        mem_model[m_addr[idx]] = t.d;
      end
      t.w = 1'b0; t.a = a; t.d = '0;
      exp_mem_q.push_back(t);
      m_valid[idx] = 1'b1; m_addr[idx] = a; m_dirty[idx] = 1'b0;
    end
    if (w) begin
      shadow[a] = d;
      m_dirty[idx] = 1'b1;
    end
    if (expect_resp) exp_q.push_back(w ? 32'h0 : arch_read(a));
  endtask

  // ---------------- memory responder ----------------
  int          stall_force = -1;
  int          stall_left  = 0;
  bit          in_req      = 0;
  bit          hold_resp   = 0;
  bit          spurious    = 0;
  bit          resp_pending = 0;
  int          resp_delay  = 0;
  logic [31:0] pend_data;
  bit          stab_chk = 0;
  logic        prev_w;
  logic [31:0] prev_a, prev_d;

  initial begin : mem_responder
    mem_txn_t t;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
    forever begin
      @(negedge CLK);
      if (stab_chk) begin
        check("mem_req_valid_stable", mem_req_valid, 1'b1);
        check("mem_req_write_stable", mem_req_write, prev_w);
        check("mem_req_addr_stable", mem_req_addr, prev_a);
        check("mem_req_wdata_stable", mem_req_wdata, prev_d);
        stab_chk = 0;
      end
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
      if (spurious) begin
        mem_resp_valid = 1'b1;
        spurious = 0;
      end else if (resp_pending && !hold_resp) begin
        if (resp_delay == 0) begin
          mem_resp_valid = 1'b1; mem_resp_rdata = pend_data; resp_pending = 0;
        end else resp_delay--;
      end
      if (mem_req_valid) begin
        if (!in_req) begin
          in_req = 1;
          stall_left = (stall_force >= 0) ? stall_force : $urandom_range(0, 2);
          stall_force = -1;
        end
        if (stall_left > 0) begin
          mem_req_ready = 1'b0;
          stall_left--;
          stab_chk = 1;
          prev_w = mem_req_write; prev_a = mem_req_addr; prev_d = mem_req_wdata;
        end else begin
          // Transfer completes on the coming rising edge.
          mem_req_ready = 1'b1;
          in_req = 0;
          if (exp_mem_q.size() == 0) fail_now("unexpected_mem_req");
          else begin
            t = exp_mem_q.pop_front();
            check("mem_req_write", mem_req_write, t.w);
            check("mem_req_addr", mem_req_addr, t.a);
            if (t.w) check("mem_req_wdata", mem_req_wdata, t.d);
          end
          if (mem_req_write) backing[mem_req_addr] = mem_req_wdata;
          else begin
            resp_pending = 1;
            resp_delay   = $urandom_range(0, 2);
            pend_data    = backing.exists(mem_req_addr) ? backing[mem_req_addr]
                                                        : init_val(mem_req_addr);
          end
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin : resp_monitor
    forever begin
      @(negedge CLK);
      if (resp_valid) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp_valid");
        else check("resp_rdata", resp_rdata, exp_q.pop_front());
        resp_seen++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input bit expect_resp, output bit hit);
    int waited;
    model_issue(w, a, d, expect_resp, hit);
    @(negedge CLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    waited = 0;
    while (!req_ready && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (!req_ready) fail_now("req_ready_timeout");
    @(negedge CLK);
    // Scramble request inputs after acceptance; they must be ignored.
    req_valid = 1'b0; req_write = 1'($urandom_range(0, 1));
    req_addr = $urandom; req_wdata = $urandom;
    check("resp_valid_one_cycle_after_hit", resp_valid, hit);
  endtask

  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d);
    bit hit;
    int target, n;
    target = resp_seen + 1;
    start_req(w, a, d, 1'b1, hit);
    n = 0;
    while (resp_seen < target && n < 300) begin
      @(negedge CLK);
      n++;
    end
    if (resp_seen < target) fail_now("resp_timeout");
    check("hit_cnt", hit_cnt, m_hits);
    check("miss_cnt", miss_cnt, m_misses);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_req_valid", mem_req_valid, 1'b0);
    check("rst_mem_req_write", mem_req_write, 1'b0);
    check("rst_mem_req_addr", mem_req_addr, 32'h0);
    check("rst_mem_req_wdata", mem_req_wdata, 32'h0);
    check("rst_hit_cnt", hit_cnt, 16'h0);
    check("rst_miss_cnt", miss_cnt, 16'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog_timeout (t=%0t)", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main_seq
    bit hit;
    int n;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    stat_load_i = 1'b0; stat_hit_val_i = '0; stat_miss_val_i = '0;
    model_reset();

    // Reset behaviour and ready rising after release.
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs();
    RST_N = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", req_ready, 1'b1);

    // Load miss then load hit on 0x10.
    preset_mem(32'h10, 32'hAAAA);
    do_req(1'b0, 32'h10, 32'h0);
    do_req(1'b0, 32'h10, 32'h0);
    check("directed_hit_cnt", hit_cnt, 16'd1);
    check("directed_miss_cnt", miss_cnt, 16'd1);

    // Store hit, then conflicting load forces writeback of 0x5555 to 0x10.
    do_req(1'b1, 32'h10, 32'h5555);
    do_req(1'b0, 32'h20, 32'h0);
    check("wb_mem_0x10", backing[32'h10], 32'h5555);

    // Store miss on a clean line, then conflict writes back the store data.
    do_req(1'b1, 32'h3, 32'hBEEF);
    do_req(1'b0, 32'h3, 32'h0);
    do_req(1'b0, 32'h23, 32'h0);
    check("wb_mem_0x3", backing[32'h3], 32'hBEEF);

    // Memory stalls for 5 cycles; stability checked by the responder.
    stall_force = 5;
    do_req(1'b0, 32'h47, 32'h0);

    // Spurious fill return while idle must change nothing.
    spurious = 1;
    repeat (3) @(negedge CLK);
    check("idle_after_spurious_ready", req_ready, 1'b1);
    check("idle_after_spurious_memreq", mem_req_valid, 1'b0);
    do_req(1'b0, 32'h47, 32'h0);

    // Randomized traffic over a small address pool to mix hits and misses.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      logic        w;
      a = 32'($urandom_range(0, 3) * 16 + $urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) a = a | 32'h8000_0000;
      w = ($urandom_range(0, 9) < 4);
      do_req(w, a, $urandom);
    end

    // Reset while waiting for a fill; the late fill return is ignored.
    do_req(1'b0, 32'h44, 32'h0);
    hold_resp = 1;
    start_req(1'b0, 32'h59, 32'h0, 1'b0, hit);
    n = 0;
    while (!resp_pending && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!resp_pending) fail_now("fill_handshake_timeout");
    @(negedge CLK);
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    check_reset_outputs();
    RST_N = 1'b1;
    model_reset();
    @(negedge CLK);
    check("ready_after_midreset", req_ready, 1'b1);
    hold_resp = 0;
    repeat (6) @(negedge CLK);
    check("no_memreq_after_late_fill", mem_req_valid, 1'b0);
    check("hit_cnt_after_midreset", hit_cnt, 16'h0);
    check("miss_cnt_after_midreset", miss_cnt, 16'h0);
    do_req(1'b0, 32'h44, 32'h0);
    check("cached_line_misses_after_reset", miss_cnt, 16'd1);

    // Miss counter saturation.
    @(negedge CLK);
    stat_load_i = 1'b1; stat_hit_val_i = m_hits; stat_miss_val_i = 16'hFFFE;
    @(negedge CLK);
    stat_load_i = 1'b0;
    m_misses = 16'hFFFE;
    check("miss_cnt_preload", miss_cnt, 16'hFFFE);
    do_req(1'b0, 32'h1000_0005, 32'h0);
    do_req(1'b0, 32'h2000_0005, 32'h0);
    do_req(1'b0, 32'h3000_0005, 32'h0);
    check("miss_cnt_saturated", miss_cnt, 16'hFFFF);

    repeat (5) @(negedge CLK);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp_mem_q_drained", 32'(exp_mem_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
